// File: rtl/uart_pkg.sv
// Shared definitions for the transmit-only UART.
//   uart_state_e       : serializer frame states
//   UART_DATA_BITS     : data bits per 8N1 frame
//   calc_clks_per_bit(): system clocks per line bit (integer division)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer with a registered TXD output.
//   clk, rst   : system clock, async active-high reset
//   start_i    : load byte_i and begin a frame (honoured in IDLE, or on the
//                final stop-bit cycle to chain frames with no idle gap)
//   byte_i     : byte to send, LSB first
//   abort_i    : return to IDLE with the line high on the next edge
//   done_o     : high on the last cycle of the stop bit
//   txd_o      : serial line, idle high
//
// state | meaning
// IDLE  | line high, waiting for start_i
// START | start bit (low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high)
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       abort_i,
  output logic       done_o,
  output logic       txd_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  // Kept outside the FSM block so the top's chaining start_i, which depends
  // on done_o, does not form a combinational loop through one process.
  assign done_o  = (state_q == STOP) && bit_end && !abort_i;
  assign txd_o   = txd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    if (abort_i) begin
      state_d = IDLE;
      baud_d  = '0;
      bit_d   = '0;
      txd_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = START;
            baud_d  = '0;
            shift_d = byte_i;
            txd_d   = 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_d = DATA;
            baud_d  = '0;
            bit_d   = '0;
            txd_d   = shift_q[0];
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_d = '0;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
              bit_d   = '0;
              txd_d   = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = shift_q >> 1;
              txd_d   = shift_q[1];
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_d = '0;
            if (start_i) begin
              state_d = START;
              shift_d = byte_i;
              txd_d   = 1'b0;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_top.sv
// Transmit-only UART front end: snapshots a CHAR_NR-byte array on an update
// pulse and sends it highest byte first as back-to-back 8N1 frames.
//   clk, rst            : system clock, async active-high reset
//   char_array_i        : characters, byte CHAR_NR-1 sent first
//   char_array_update_i : start request (ignored while busy)
//   clr_i               : synchronous abort (wins over an update)
//   busy_o              : high from the cycle after the update edge until the
//                         edge that ends the last stop bit
//   txd_o               : serial line, idle high
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int CHAR_NR     = 8,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHAR_NR*8-1:0] char_array_i,
  input  logic                 char_array_update_i,
  input  logic                 clr_i,
  output logic                 busy_o,
  output logic                 txd_o
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int IW = (CHAR_NR > 1) ? $clog2(CHAR_NR) : 1;

  logic [CHAR_NR*8-1:0] shadow_q;
  logic [IW-1:0]        idx_q, idx_m1;
  logic                 busy_q;
  logic                 launch, chain, byte_done, byte_start;
  logic [7:0]           byte_sel;

  assign idx_m1 = idx_q - IW'(1);

  // The first byte comes straight from the input so the start bit can leave
  // on the very edge that snapshots the array; later bytes come from the shadow.
  assign launch     = !busy_q && char_array_update_i && !clr_i;
  assign chain      = busy_q && byte_done && (idx_q != '0) && !clr_i;
  assign byte_start = launch || chain;
  assign byte_sel   = launch ? char_array_i[CHAR_NR*8-1 -: 8]
                             : shadow_q[UART_DATA_BITS*int'(idx_m1) +: UART_DATA_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
    end else if (clr_i) begin
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else if (launch) begin
      shadow_q <= char_array_i;
      idx_q    <= IW'(CHAR_NR - 1);
      busy_q   <= 1'b1;
    end else if (chain) begin
      idx_q <= idx_m1;
    end else if (busy_q && byte_done) begin
      busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk     (clk),
    .rst     (rst),
    .start_i (byte_start),
    .byte_i  (byte_sel),
    .abort_i (clr_i),
    .done_o  (byte_done),
    .txd_o   (txd_o)
  );

endmodule

// File: tb/tb_uart_tx_top.sv
module tb_uart_tx_top;

  localparam int CHARS = 8;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD = 7_000_000;
  localparam int CPB = CLK_HZ / BAUD;  // 14
  localparam int FRAME = 10 * CPB;
  localparam int FULL = CHARS * FRAME;

  logic clk, rst;
  logic [CHARS*8-1:0] char_array_i;
  logic char_array_update_i, clr_i;
  logic busy_o, txd_o;

  int total = 0;
  int bad = 0;

  uart_tx_top #(
    .CHAR_NR(CHARS),
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .char_array_i(char_array_i),
    .char_array_update_i(char_array_update_i),
    .clr_i(clr_i),
    .busy_o(busy_o),
    .txd_o(txd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line must stay idle (busy 0, txd 1) for n cycles.
  task automatic idle_check(input string tag, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || txd_o !== 1'b1) errs++;
      char_array_update_i = 1'b0;
      clr_i = 1'b0;
    end
    chk(tag, 64'(errs), 64'd0);
  endtask

  // Starts a transmission of arr and checks every cycle against the ideal
  // 8N1 waveform; a mid-bit receiver decodes each byte. Optional perturbations
  // at cycle k: extra update pulse, input array change, clr pulse.
  task automatic tx_check(input string tag, input logic [63:0] arr,
                          input int upd_at, input int chg_at, input int clr_at);
    int span, frame, pos, line_err, busy_err;
    logic exp_txd;
    logic [7:0] rx, exp_b;
    span = (clr_at >= 0) ? clr_at + 1 : FULL;
    line_err = 0;
    busy_err = 0;
    rx = '0;
    @(negedge clk);
    char_array_i = arr;
    char_array_update_i = 1'b1;
    for (int k = 0; k < span; k++) begin
      @(negedge clk);
      char_array_update_i = 1'b0;
      clr_i = 1'b0;
      frame = k / FRAME;
      pos = (k % FRAME) / CPB;
      exp_b = arr[8*(CHARS-1-frame) +: 8];
      if (pos == 0) exp_txd = 1'b0;
      else if (pos == 9) exp_txd = 1'b1;
      else exp_txd = exp_b[pos-1];
      if (txd_o !== exp_txd) line_err++;
      if (busy_o !== 1'b1) busy_err++;
      if (pos >= 1 && pos <= 8 && (k % CPB) == CPB/2) rx[pos-1] = txd_o;
      if (pos == 9 && (k % CPB) == CPB/2)
        chk($sformatf("%s_byte%0d", tag, frame), 64'(rx), 64'(exp_b));
      if (k == upd_at) char_array_update_i = 1'b1;
      if (k == chg_at) char_array_i = {$urandom, $urandom};
      if (k == clr_at) clr_i = 1'b1;
    end
    @(negedge clk);
    clr_i = 1'b0;
    chk({tag, "_end_idle"}, {62'd0, busy_o, txd_o}, 64'b01);
    chk({tag, "_line"}, 64'(line_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy_err), 64'd0);
  endtask

  initial begin
    logic [63:0] arr;
    int cut;
    char_array_i = '0;
    char_array_update_i = 1'b0;
    clr_i = 1'b0;
    rst = 1'b1;

    // 1. reset then idle
    @(negedge clk);
    chk("reset_state", {62'd0, busy_o, txd_o}, 64'b01);
    rst = 1'b0;
    idle_check("idle_after_reset", 30);

    // 2. full array
    tx_check("full_HGFE", "HGFE7CBA", -1, -1, -1);

    // 3. back-to-back, update at 150 ns ignored
    tx_check("thomas_ign", "THOMAS99", 15, -1, -1);

    // 4. abort at 160 ns, idle hold, restart 100 ns later
    tx_check("abort", "THOMAS99", -1, -1, 16);
    idle_check("abort_hold", 9);
    tx_check("restart", "THOMAS99", -1, -1, -1);

    // 5. collision: update and clr together
    @(negedge clk);
    char_array_i = "COLLIDE!";
    char_array_update_i = 1'b1;
    clr_i = 1'b1;
    idle_check("collision", 3 * CPB);

    // 5. shadowing: input changes mid-transmission
    tx_check("shadow", "SNAPSHOT", -1, 200, -1);

    // random arrays and random abort points
    for (int r = 0; r < 3; r++) begin
      arr = {$urandom, $urandom};
      tx_check($sformatf("rand%0d", r), arr, $urandom_range(FULL-2, 1), -1, -1);
    end
    for (int r = 0; r < 2; r++) begin
      arr = {$urandom, $urandom};
      cut = $urandom_range(FULL-2, 1);
      tx_check($sformatf("rclr%0d", r), arr, -1, -1, cut);
      idle_check($sformatf("rclr%0d_hold", r), 5);
    end

    // 6. async reset during a data bit of 'H' that is 0
    @(negedge clk);
    char_array_i = "HGFE7CBA";
    char_array_update_i = 1'b1;
    @(negedge clk);
    char_array_update_i = 1'b0;
    repeat (2*CPB + CPB/2) @(negedge clk);
    chk("pre_rst_data", {62'd0, busy_o, txd_o}, 64'b10);
    #1 rst = 1'b1;
    #1 chk("async_rst", {62'd0, busy_o, txd_o}, 64'b01);
    @(negedge clk);
    rst = 1'b0;
    idle_check("post_rst_idle", 20);
    tx_check("post_rst_tx", "ABCDEFGH", -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_top.md
Name: uart_tx_top

Overview:
Transmit-only UART front end that serializes a fixed-length character array onto a single TXD line, using 8N1 framing. A one-cycle update pulse snapshots the array and starts transmission. The highest-order byte is sent first, and busy_o stays high until the last stop bit completes. The block sits between the display/measurement formatting logic and the board's USB-UART TX pin.

Parameters:
- CHAR_NR, 8: number of characters per array; the array is CHAR_NR*8 bits wide. Must be ≥1.
- CLK_FREQ_HZ, 100_000_000: system clock frequency.
- BAUD_RATE, 115200: line rate.
- CLKS_PER_BIT is derived as CLK_FREQ_HZ/BAUD_RATE, integer division. This gives 868 at the defaults.

Ports:
- clk, in, 1: system clock. All logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- char_array_i, in, CHAR_NR*8: characters to send. Byte CHAR_NR-1 (bits [CHAR_NR*8-1 -: 8]) is sent first; byte 0 is sent last.
- char_array_update_i, in, 1: start request, sampled at rising edges.
- clr_i, in, 1: synchronous abort request.
- busy_o, out, 1: high while a transmission is in progress.
- txd_o, out, 1: serial output. Idle level is high.

Behaviour:
- Reset (async, active-high):
  - txd_o=1, busy_o=0.
  - State machine in IDLE; all counters 0; shadow register cleared.
- States and transitions:
  - IDLE → START when char_array_update_i=1 and clr_i=0.
    - On that same edge, char_array_i is copied into a shadow register and the char index is set to CHAR_NR-1.
  - START: txd_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: txd_o=1 for CLKS_PER_BIT cycles.
    - If index>0: decrement the index and go directly to START. There is no idle gap between characters.
    - If index=0: go to IDLE.
- Outputs are registered:
  - busy_o and the first start bit appear on the cycle after the update edge.
  - busy_o falls on the same edge that ends the last stop bit.
- Timing at defaults:
  - One frame is 10*868 = 8680 cycles.
  - A full 8-character array is 69440 cycles.
- Input handling while busy:
  - char_array_update_i while busy is ignored; it is neither queued nor a restart.
  - char_array_i changes after the update edge do not affect the frames in flight.
- clr_i=1 in any non-IDLE state:
  - On the next edge, go to IDLE, txd_o=1, busy_o=0, counters 0. A partial frame may be truncated.
  - clr_i in IDLE has no effect.
- Simultaneous clr_i and char_array_update_i: clr_i wins and no transmission starts.
- A new update after clr (or after completion) restarts from byte CHAR_NR-1 of the current char_array_i.
- Counters:
  - The baud counter runs 0..CLKS_PER_BIT-1 and wraps.
  - The bit counter runs 0..7.
  - The char index is $clog2(CHAR_NR) bits wide, minimum 1.
- Reset mid-frame: immediate return to the reset state, with txd_o high asynchronously.

Decomposition:
- Package uart_pkg contains:
  - the state enum typedef (IDLE, START, DATA, STOP);
  - a function computing CLKS_PER_BIT;
  - the constant UART_DATA_BITS=8.
- One sub-module, uart_tx_byte, handles single-byte 8N1 serialization:
  - ports: start pulse, byte in, abort, done pulse, txd.
- uart_tx_top holds:
  - the shadow register;
  - the char index sequencing;
  - the busy_o and clr_i handling.

Test Plan:
1. Reset then idle.
   - Stimulus: rst high for 1 cycle, then release, no stimulus.
   - Required: txd_o=1 and busy_o=0 throughout.
2. Full array send.
   - Stimulus: array "HGFE7CBA" with a 1-cycle update pulse.
   - Required: busy_o rises 1 cycle later.
   - First frame is 0x48 ('H'): bits 0,0,0,1,0,0,1,0 LSB first, each 868 cycles.
   - Characters follow in order H,G,F,E,7,C,B,A.
   - busy_o falls after exactly 69440 cycles.
3. Back-to-back arrays.
   - Stimulus: after busy_o falls, load "THOMAS99" and pulse update.
   - Required: the first decoded byte is 0x54 ('T').
   - An update pulse 150 ns into the transmission is ignored.
4. Abort.
   - Stimulus: pulse clr_i 160 ns after start.
   - Required: next cycle busy_o=0 and txd_o=1, held until the next update.
   - A later update (100 ns on) restarts from 'T' and completes all 8 frames.
5. Collision and shadowing.
   - Stimulus: update and clr_i asserted in the same cycle.
   - Required: no start bit and busy_o stays 0.
   - Stimulus: char_array_i changed mid-transmission.
   - Required: the decoded bytes still equal the snapshot.
6. Async reset mid-frame.
   - Stimulus: assert rst during a DATA bit.
   - Required: txd_o=1 and busy_o=0 without waiting for a clock edge.
